// File: rtl/raster_pkg.sv
// Shared types and helpers for the triangle rasterizer front end.
package raster_pkg;

  localparam int COORD_W = 11;

  typedef logic signed [COORD_W-1:0] coord_s_t;  // vertex coordinate
  typedef logic        [COORD_W-1:0] coord_u_t;  // on-screen pixel coordinate
  typedef logic signed [COORD_W:0]   coord_e_t;  // one guard bit so compares never wrap

  typedef struct packed {
    coord_s_t x;
    coord_s_t y;
  } vertex_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2
  } scan_state_t;

  function automatic coord_e_t sext(input coord_s_t c);
    return {c[COORD_W-1], c};
  endfunction

  function automatic coord_e_t min3(input coord_e_t a, input coord_e_t b, input coord_e_t c);
    coord_e_t m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic coord_e_t max3(input coord_e_t a, input coord_e_t b, input coord_e_t c);
    coord_e_t m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/bbox_clamp.sv
// Combinational bounding box of three vertices, clamped to the visible screen.
// The bounds are only meaningful when empty is low; an inverted range after
// clamping means the triangle lies entirely off-screen.
module bbox_clamp
  import raster_pkg::*;
#(
  parameter int H_RES = 800,
  parameter int V_RES = 600
) (
  input  logic signed [COORD_W-1:0] v1_x,
  input  logic signed [COORD_W-1:0] v1_y,
  input  logic signed [COORD_W-1:0] v2_x,
  input  logic signed [COORD_W-1:0] v2_y,
  input  logic signed [COORD_W-1:0] v3_x,
  input  logic signed [COORD_W-1:0] v3_y,
  output logic        [COORD_W-1:0] bx0,
  output logic        [COORD_W-1:0] bx1,
  output logic        [COORD_W-1:0] by0,
  output logic        [COORD_W-1:0] by1,
  output logic                      empty
);

  localparam coord_e_t X_MAX = coord_e_t'(H_RES - 1);
  localparam coord_e_t Y_MAX = coord_e_t'(V_RES - 1);
  localparam coord_e_t ZERO  = coord_e_t'(0);

  coord_e_t min_x, max_x, min_y, max_y;
  coord_e_t lo_x, hi_x, lo_y, hi_y;

  // Raw extent in guarded width, clamp each side, then flag an inverted range
  always_comb begin
    min_x = min3(sext(v1_x), sext(v2_x), sext(v3_x));
    max_x = max3(sext(v1_x), sext(v2_x), sext(v3_x));
    min_y = min3(sext(v1_y), sext(v2_y), sext(v3_y));
    max_y = max3(sext(v1_y), sext(v2_y), sext(v3_y));

    lo_x = (min_x < ZERO)  ? ZERO  : min_x;
    hi_x = (max_x > X_MAX) ? X_MAX : max_x;
    lo_y = (min_y < ZERO)  ? ZERO  : min_y;
    hi_y = (max_y > Y_MAX) ? Y_MAX : max_y;

    empty = (lo_x > hi_x) || (lo_y > hi_y);

    // Low bounds are never negative and high bounds are only negative when
    // empty is set, so dropping the guard bit is safe for every used value.
    bx0 = lo_x[COORD_W-1:0];
    bx1 = hi_x[COORD_W-1:0];
    by0 = lo_y[COORD_W-1:0];
    by1 = hi_y[COORD_W-1:0];
  end

endmodule

// File: rtl/tri_bbox_scanner.sv
// Triangle bounding-box scanner: accepts one triangle, clamps its bounding box
// to the screen and walks every pixel of the box in raster order, one pixel
// per accepted beat, carrying the latched vertices alongside.
module tri_bbox_scanner
  import raster_pkg::*;
#(
  parameter int H_RES = 800,
  parameter int V_RES = 600
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tri_valid,
  output logic                      tri_ready,
  input  logic signed [COORD_W-1:0] V1_x,
  input  logic signed [COORD_W-1:0] V1_y,
  input  logic signed [COORD_W-1:0] V2_x,
  input  logic signed [COORD_W-1:0] V2_y,
  input  logic signed [COORD_W-1:0] V3_x,
  input  logic signed [COORD_W-1:0] V3_y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic        [COORD_W-1:0] pixel_x,
  output logic        [COORD_W-1:0] pixel_y,
  output logic signed [COORD_W-1:0] V1_x_out,
  output logic signed [COORD_W-1:0] V1_y_out,
  output logic signed [COORD_W-1:0] V2_x_out,
  output logic signed [COORD_W-1:0] V2_y_out,
  output logic signed [COORD_W-1:0] V3_x_out,
  output logic signed [COORD_W-1:0] V3_y_out,
  output logic                      out_last,
  output logic                      tri_done,
  output logic                      busy
);

  scan_state_t state_q, state_d;
  vertex_t     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  coord_u_t    px_q, px_d, py_q, py_d;
  coord_u_t    bx0_q, bx0_d, bx1_q, bx1_d;
  coord_u_t    by0_q, by0_d, by1_q, by1_d;
  logic        tri_done_q, tri_done_d;

  coord_u_t    bb_x0, bb_x1, bb_y0, bb_y1;
  logic        bb_empty;
  logic        at_row_end, at_last;

  // Box is derived from the latched vertices, so it is valid during SETUP
  bbox_clamp #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_bbox (
    .v1_x  (v1_q.x),
    .v1_y  (v1_q.y),
    .v2_x  (v2_q.x),
    .v2_y  (v2_q.y),
    .v3_x  (v3_q.x),
    .v3_y  (v3_q.y),
    .bx0   (bb_x0),
    .bx1   (bb_x1),
    .by0   (bb_y0),
    .by1   (bb_y1),
    .empty (bb_empty)
  );

  // Position of the current pixel relative to the stored box corners
  always_comb begin
    at_row_end = (px_q == bx1_q);
    at_last    = at_row_end && (py_q == by1_q);
  end

  // Next-state logic: accept, set up the box, then step through it
  always_comb begin
    state_d    = state_q;
    v1_d       = v1_q;
    v2_d       = v2_q;
    v3_d       = v3_q;
    px_d       = px_q;
    py_d       = py_q;
    bx0_d      = bx0_q;
    bx1_d      = bx1_q;
    by0_d      = by0_q;
    by1_d      = by1_q;
    tri_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (tri_valid) begin
          v1_d.x  = V1_x;
          v1_d.y  = V1_y;
          v2_d.x  = V2_x;
          v2_d.y  = V2_y;
          v3_d.x  = V3_x;
          v3_d.y  = V3_y;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (bb_empty) begin
          // Nothing visible: finish without ever raising out_valid
          tri_done_d = 1'b1;
          state_d    = IDLE;
        end else begin
          bx0_d   = bb_x0;
          bx1_d   = bb_x1;
          by0_d   = bb_y0;
          by1_d   = bb_y1;
          px_d    = bb_x0;
          py_d    = bb_y0;
          state_d = SCAN;
        end
      end

      SCAN: begin
        if (out_ready) begin
          if (at_last) begin
            tri_done_d = 1'b1;
            state_d    = IDLE;
          end else if (at_row_end) begin
            px_d = bx0_q;
            py_d = py_q + coord_u_t'(1);
          end else begin
            px_d = px_q + coord_u_t'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, box corners and latched vertices
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      v1_q       <= '0;
      v2_q       <= '0;
      v3_q       <= '0;
      px_q       <= '0;
      py_q       <= '0;
      bx0_q      <= '0;
      bx1_q      <= '0;
      by0_q      <= '0;
      by1_q      <= '0;
      tri_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      v3_q       <= v3_d;
      px_q       <= px_d;
      py_q       <= py_d;
      bx0_q      <= bx0_d;
      bx1_q      <= bx1_d;
      by0_q      <= by0_d;
      by1_q      <= by1_d;
      tri_done_q <= tri_done_d;
    end
  end

  // Outputs decode directly from registers so reset clears them immediately
  always_comb begin
    tri_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == SCAN);
    out_last  = (state_q == SCAN) && at_last;
    tri_done  = tri_done_q;
    pixel_x   = px_q;
    pixel_y   = py_q;
    V1_x_out  = v1_q.x;
    V1_y_out  = v1_q.y;
    V2_x_out  = v2_q.x;
    V2_y_out  = v2_q.y;
    V3_x_out  = v3_q.x;
    V3_y_out  = v3_q.y;
  end

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// Scoreboard bench for tri_bbox_scanner on a reduced 80x60 screen.
module tb_tri_bbox_scanner;

  localparam int W  = 11;
  localparam int HR = 80;
  localparam int VR = 60;

  logic                clk = 1'b0;
  logic                rst;
  logic                tri_valid;
  logic                tri_ready;
  logic signed [W-1:0] V1_x, V1_y, V2_x, V2_y, V3_x, V3_y;
  logic                out_valid;
  logic                out_ready;
  logic        [W-1:0] pixel_x, pixel_y;
  logic signed [W-1:0] V1_x_out, V1_y_out, V2_x_out, V2_y_out, V3_x_out, V3_y_out;
  logic                out_last, tri_done, busy;

  tri_bbox_scanner #(.H_RES(HR), .V_RES(VR)) dut (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .V1_x(V1_x), .V1_y(V1_y), .V2_x(V2_x), .V2_y(V2_y), .V3_x(V3_x), .V3_y(V3_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .V1_x_out(V1_x_out), .V1_y_out(V1_y_out), .V2_x_out(V2_x_out),
    .V2_y_out(V2_y_out), .V3_x_out(V3_x_out), .V3_y_out(V3_y_out),
    .out_last(out_last), .tri_done(tri_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x; int y; bit last;
    int v1x; int v1y; int v2x; int v2y; int v3x; int v3y;
  } beat_t;

  beat_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    beats = 0;
  int    done_at = -10;
  int    cull_at = -10;
  int    rmode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, msg);
    end
  endtask

  // Reference: clamp the box with plain integer arithmetic and enumerate it
  function automatic int plan_tri(input int ax, ay, bx, by, cx, cy);
    int x0, x1, y0, y1, n;
    beat_t b;
    x0 = (ax < bx) ? ax : bx;  x0 = (cx < x0) ? cx : x0;
    x1 = (ax > bx) ? ax : bx;  x1 = (cx > x1) ? cx : x1;
    y0 = (ay < by) ? ay : by;  y0 = (cy < y0) ? cy : y0;
    y1 = (ay > by) ? ay : by;  y1 = (cy > y1) ? cy : y1;
    if (x0 < 0) x0 = 0;
    if (y0 < 0) y0 = 0;
    if (x1 > HR - 1) x1 = HR - 1;
    if (y1 > VR - 1) y1 = VR - 1;
    n = 0;
    if (x0 > x1 || y0 > y1) return 0;
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        b.x = x; b.y = y; b.last = (x == x1) && (y == y1);
        b.v1x = ax; b.v1y = ay; b.v2x = bx; b.v2y = by; b.v3x = cx; b.v3y = cy;
        sb.push_back(b);
        n++;
      end
    return n;
  endfunction

  // Present a triangle, wait (bounded) for acceptance, queue its expected beats
  task automatic send_tri(input int ax, ay, bx, by, cx, cy, output int acc);
    bit got;
    int n;
    V1_x = ax[W-1:0]; V1_y = ay[W-1:0];
    V2_x = bx[W-1:0]; V2_y = by[W-1:0];
    V3_x = cx[W-1:0]; V3_y = cy[W-1:0];
    tri_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (tri_ready) got = 1'b1;
    end
    if (!got) begin
      chk(1'b0, "accept_timeout", $sformatf("tri_ready=%0b required=1", tri_ready));
      tri_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    n = plan_tri(ax, ay, bx, by, cx, cy);
    if (n == 0) cull_at = acc + 1;
    tri_valid = 1'b0;
    V1_x = W'($urandom); V1_y = W'($urandom); V2_x = W'($urandom);
    V2_y = W'($urandom); V3_x = W'($urandom); V3_y = W'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && tri_ready) got = 1'b1;
    end
    chk(got, "drain_timeout", $sformatf("queue=%0d tri_ready=%0b required queue=0 ready=1", sb.size(), tri_ready));
    @(posedge clk);
    #1;
  endtask

  // Downstream ready pattern generator
  initial begin
    int pidx;
    int prev;
    bit [3:0] pat;
    pat = 4'b1001;
    pidx = 0;
    prev = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rmode != prev) begin pidx = 0; prev = rmode; end
      case (rmode)
        0: out_ready = 1'b1;
        1: begin out_ready = pat[pidx]; pidx = (pidx + 1) % 4; end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compare every presented beat with the queue head, pop on handshake
  bit    stalled = 1'b0;
  bit    exp_done;
  beat_t me;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      exp_done = (cyc == done_at) || (cyc == cull_at);
      if (tri_done || exp_done)
        chk(tri_done == exp_done, "tri_done", $sformatf("cyc=%0d got %0b required %0b", cyc, tri_done, exp_done));
      if (stalled && !out_valid)
        chk(1'b0, "valid_drop", "out_valid=0 required 1 (no handshake)");
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_beat", $sformatf("got (%0d,%0d) required none", pixel_x, pixel_y));
        end else begin
          me = sb[0];
          chk(int'(pixel_x) == me.x && int'(pixel_y) == me.y && out_last == me.last &&
              int'(V1_x_out) == me.v1x && int'(V1_y_out) == me.v1y &&
              int'(V2_x_out) == me.v2x && int'(V2_y_out) == me.v2y &&
              int'(V3_x_out) == me.v3x && int'(V3_y_out) == me.v3y,
              out_ready ? "beat" : "stall_beat",
              $sformatf("got (%0d,%0d) last=%0b v=%0d,%0d,%0d,%0d,%0d,%0d required (%0d,%0d) last=%0b v=%0d,%0d,%0d,%0d,%0d,%0d",
                        pixel_x, pixel_y, out_last, V1_x_out, V1_y_out, V2_x_out, V2_y_out, V3_x_out, V3_y_out,
                        me.x, me.y, me.last, me.v1x, me.v1y, me.v2x, me.v2y, me.v3x, me.v3y));
          if (out_ready) begin
            void'(sb.pop_front());
            beats++;
            if (me.last) done_at = cyc + 1;
          end
        end
      end
      stalled = out_valid && !out_ready;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, n0;
    int cx, cy;
    rst = 1'b1;
    tri_valid = 1'b0;
    V1_x = '0; V1_y = '0; V2_x = '0; V2_y = '0; V3_x = '0; V3_y = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk(tri_ready == 1'b1, "rst_ready", $sformatf("got %0b required 1", tri_ready));
    chk(out_valid == 1'b0 && busy == 1'b0 && tri_done == 1'b0 && out_last == 1'b0, "rst_ctrl",
        $sformatf("valid=%0b busy=%0b done=%0b last=%0b required all 0", out_valid, busy, tri_done, out_last));
    chk(pixel_x == 0 && pixel_y == 0 && V1_x_out == 0 && V3_y_out == 0, "rst_data",
        $sformatf("px=%0d py=%0d v1x=%0d v3y=%0d required 0", pixel_x, pixel_y, V1_x_out, V3_y_out));

    // Small triangle, full throughput, latency and cadence
    rmode = 0;
    send_tri(2, 2, 5, 2, 2, 4, a);
    chk(out_valid == 1'b0 && tri_ready == 1'b0 && busy == 1'b1, "setup_cycle",
        $sformatf("valid=%0b ready=%0b busy=%0b required 0,0,1", out_valid, tri_ready, busy));
    @(posedge clk); #1;
    chk(out_valid == 1'b1 && pixel_x == 2 && pixel_y == 2, "first_beat_latency",
        $sformatf("valid=%0b (%0d,%0d) required 1 (2,2)", out_valid, pixel_x, pixel_y));
    for (int i = 0; i < 12; i++) begin
      chk(out_valid == 1'b1, "cadence", $sformatf("beat %0d valid=%0b required 1", i, out_valid));
      @(posedge clk); #1;
    end
    chk(out_valid == 1'b0 && tri_done == 1'b1 && tri_ready == 1'b1, "end_of_tri",
        $sformatf("valid=%0b done=%0b ready=%0b required 0,1,1", out_valid, tri_done, tri_ready));

    // Same triangle with a stalling downstream
    rmode = 1;
    send_tri(2, 2, 5, 2, 2, 4, a);
    wait_idle(500);
    rmode = 0;

    // Fully off-screen triangle is culled
    send_tri(-10, -10, -5, -1, -3, -8, a);
    chk(out_valid == 1'b0 && tri_ready == 1'b0 && tri_done == 1'b0, "cull_setup",
        $sformatf("valid=%0b ready=%0b done=%0b required 0,0,0", out_valid, tri_ready, tri_done));
    @(posedge clk); #1;
    chk(tri_done == 1'b1 && tri_ready == 1'b1 && out_valid == 1'b0, "cull_done",
        $sformatf("done=%0b ready=%0b valid=%0b required 1,1,0", tri_done, tri_ready, out_valid));
    @(posedge clk); #1;
    chk(tri_done == 1'b0, "cull_pulse_width", $sformatf("done=%0b required 0", tri_done));

    // Clipping on every side: whole screen
    n0 = beats;
    send_tri(-5, -5, 820, 3, 10, 610, a);
    wait_idle(20000);
    chk(beats - n0 == HR * VR, "clip_count", $sformatf("got %0d beats required %0d", beats - n0, HR * VR));

    // Single point, then back-to-back triangle held while busy
    send_tri(7, 7, 7, 7, 7, 7, a);
    send_tri(30, 40, 33, 41, 31, 45, b);
    chk(b - a == 3, "b2b_accept", $sformatf("accept gap %0d cycles required 3", b - a));
    wait_idle(500);

    // Asynchronous reset in the middle of a scan
    send_tri(2, 2, 5, 2, 2, 4, a);
    repeat (6) @(posedge clk);
    #2;
    chk(out_valid == 1'b1 && pixel_x == 3 && pixel_y == 3, "pre_reset_beat",
        $sformatf("valid=%0b (%0d,%0d) required 1 (3,3)", out_valid, pixel_x, pixel_y));
    rst = 1'b1;
    #1;
    chk(out_valid == 1'b0 && busy == 1'b0 && tri_done == 1'b0 && tri_ready == 1'b1, "async_reset",
        $sformatf("valid=%0b busy=%0b done=%0b ready=%0b required 0,0,0,1", out_valid, busy, tri_done, tri_ready));
    sb.delete();
    done_at = -10;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk(tri_ready == 1'b1 && V1_x_out == 0 && pixel_x == 0, "post_reset",
        $sformatf("ready=%0b v1x=%0d px=%0d required 1,0,0", tri_ready, V1_x_out, pixel_x));
    send_tri(10, 20, 14, 18, 12, 23, a);
    wait_idle(500);

    // Randomized triangles with random backpressure
    rmode = 2;
    for (int t = 0; t < 30; t++) begin
      cx = int'($urandom_range(0, 140)) - 30;
      cy = int'($urandom_range(0, 120)) - 30;
      send_tri(cx + int'($urandom_range(0, 16)) - 8, cy + int'($urandom_range(0, 16)) - 8,
               cx + int'($urandom_range(0, 16)) - 8, cy + int'($urandom_range(0, 16)) - 8,
               cx + int'($urandom_range(0, 16)) - 8, cy + int'($urandom_range(0, 16)) - 8, a);
      if ($urandom_range(0, 1) == 0) wait_idle(3000);
    end
    wait_idle(3000);
    chk(sb.size() == 0, "drain", $sformatf("%0d beats outstanding required 0", sb.size()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
